mem_arbiter: RTL and testbench

Two-core memory arbiter that shares the single-port RAM between the four L1 requesters: icache and dcache of core 0, icache and dcache of core 1. It sits between the caches' controller ports and the RAM model.
- Dcache traffic is two-word block transfers (fills and writebacks). A granted dcache is locked to the RAM for both words.
- Icache traffic is single-word fetches.
- Arbitration between cores is round-robin. Within a core, dcache has priority over icache.

---
 rtl/cpu_types_pkg.sv | 20 ++
 rtl/rr_pick.sv | 33 +++
 rtl/mem_arbiter.sv | 117 +++++++++++
 tb/tb_mem_arbiter.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared types for the memory arbiter: RAM handshake state, word type,
// arbiter FSM states and the grant record.
package cpu_types_pkg;

  localparam int NCORE = 2;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;

  typedef enum logic [1:0] {IDLE, IXFER, DXFER1, DXFER2} memarb_state_t;

  typedef enum logic {GT_I = 1'b0, GT_D = 1'b1} gtype_t;

  typedef struct packed {
    logic   gcore;
    gtype_t gtype;
  } grant_t;

endpackage

// File: rtl/rr_pick.sv
// Priority selector: round-robin between cores starting after last_core,
// dcache requests beat icache requests regardless of core.
module rr_pick
  import cpu_types_pkg::*;
(
  input  logic [NCORE-1:0] ireq,
  input  logic [NCORE-1:0] dreq,
  input  logic             last_core,
  output logic             valid,
  output grant_t           pick
);

  logic first;
  assign first = ~last_core;

  always_comb begin
    valid = 1'b1;
    pick  = '{gcore: first, gtype: GT_D};
    if (dreq[first]) begin
      pick = '{gcore: first, gtype: GT_D};
    end else if (dreq[last_core]) begin
      pick = '{gcore: last_core, gtype: GT_D};
    end else if (ireq[first]) begin
      pick = '{gcore: first, gtype: GT_I};
    end else if (ireq[last_core]) begin
      pick = '{gcore: last_core, gtype: GT_I};
    end else begin
      valid = 1'b0;
      pick  = '{gcore: 1'b0, gtype: GT_I};
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port RAM between the icache/dcache of two cores.
// Dcache grants hold the RAM for a two-word burst; each transaction ends with an IDLE bubble.
module mem_arbiter
  import cpu_types_pkg::*;
(
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [NCORE-1:0]      iREN,
  input  logic [NCORE-1:0][31:0] iaddr,
  input  logic [NCORE-1:0]      dREN,
  input  logic [NCORE-1:0]      dWEN,
  input  logic [NCORE-1:0][31:0] daddr,
  input  logic [NCORE-1:0][31:0] dstore,
  output logic [NCORE-1:0]      iwait,
  output logic [NCORE-1:0]      dwait,
  output logic [NCORE-1:0][31:0] iload,
  output logic [NCORE-1:0][31:0] dload,
  output logic                  ramREN,
  output logic                  ramWEN,
  output word_t                 ramaddr,
  output word_t                 ramstore,
  input  word_t                 ramload,
  input  ramstate_t             ramstate,
  output logic                  err,
  output memarb_state_t         arb_state
);

  memarb_state_t state, next_state;
  grant_t        grant, pick;
  logic          pick_valid;
  logic          last_core;
  logic          g_iren, g_dren, g_dwen;
  logic          xfer, live, done, abort, to_idle;

  rr_pick u_rr_pick (
    .ireq      (iREN),
    .dreq      (dREN | dWEN),
    .last_core (last_core),
    .valid     (pick_valid),
    .pick      (pick)
  );

  assign g_iren = iREN[grant.gcore];
  assign g_dren = dREN[grant.gcore];
  assign g_dwen = dWEN[grant.gcore];

  // A granted requester that drops its request lines aborts the transaction.
  assign xfer  = (state != IDLE);
  assign live  = (grant.gtype == GT_D) ? (g_dren | g_dwen) : g_iren;
  assign done  = xfer && live && (ramstate == ACCESS || ramstate == ERROR);
  assign abort = xfer && !live;

  assign iload     = {NCORE{ramload}};
  assign dload     = {NCORE{ramload}};
  assign arb_state = state;

  always_comb begin
    next_state = state;
    to_idle    = 1'b0;
    ramREN     = 1'b0;
    ramWEN     = 1'b0;
    ramaddr    = '0;
    ramstore   = '0;
    iwait      = '1;
    dwait      = '1;

    case (state)
      IDLE: begin
        if (pick_valid) next_state = (pick.gtype == GT_D) ? DXFER1 : IXFER;
      end
      IXFER, DXFER2: begin
        if (abort || done) begin
          next_state = IDLE;
          to_idle    = 1'b1;
        end
      end
      DXFER1: begin
        if (abort) begin
          next_state = IDLE;
          to_idle    = 1'b1;
        end else if (done) begin
          next_state = DXFER2;
        end
      end
      default: next_state = IDLE;
    endcase

    if (xfer) begin
      ramstore = dstore[grant.gcore];
      if (grant.gtype == GT_D) begin
        ramWEN  = g_dwen;
        ramREN  = g_dren & ~g_dwen;
        ramaddr = daddr[grant.gcore];
        if (done) dwait[grant.gcore] = 1'b0;
      end else begin
        ramREN  = g_iren;
        ramaddr = iaddr[grant.gcore];
        if (done) iwait[grant.gcore] = 1'b0;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      grant     <= '{gcore: 1'b0, gtype: GT_I};
      last_core <= 1'b1;
      err       <= 1'b0;
    end else begin
      state <= next_state;
      if (state == IDLE && pick_valid) grant <= pick;
      if (to_idle) last_core <= grant.gcore;
      if (done && ramstate == ERROR) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: inputs change 1 ns after the rising edge,
// outputs are checked on the falling edge against hand-computed values.
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  logic              CLK = 1'b0;
  logic              RST;
  logic [1:0]        iREN, dREN, dWEN;
  logic [1:0][31:0]  iaddr, daddr, dstore;
  logic [1:0]        iwait, dwait;
  logic [1:0][31:0]  iload, dload;
  logic              ramREN, ramWEN;
  word_t             ramaddr, ramstore, ramload;
  ramstate_t         ramstate;
  logic              err;
  memarb_state_t     arb_state;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  mem_arbiter dut (
    .CLK       (CLK),
    .RST       (RST),
    .iREN      (iREN),
    .iaddr     (iaddr),
    .dREN      (dREN),
    .dWEN      (dWEN),
    .daddr     (daddr),
    .dstore    (dstore),
    .iwait     (iwait),
    .dwait     (dwait),
    .iload     (iload),
    .dload     (dload),
    .ramREN    (ramREN),
    .ramWEN    (ramWEN),
    .ramaddr   (ramaddr),
    .ramstore  (ramstore),
    .ramload   (ramload),
    .ramstate  (ramstate),
    .err       (err),
    .arb_state (arb_state)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic sample();
    @(negedge CLK);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  logic [31:0] rr_d [4];
  logic [31:0] rr_i [4];

  initial begin
    rr_d = '{32'h400, 32'h300, 32'h400, 32'h300};
    rr_i = '{32'h44, 32'h40, 32'h44, 32'h40};

    RST = 1'b1; iREN = '0; dREN = '0; dWEN = '0;
    iaddr = '0; daddr = '0; dstore = '0; ramload = '0; ramstate = FREE;

    // reset values
    sample();
    check("rst_state", 32'(arb_state), 32'(IDLE));
    check("rst_iwait", 32'(iwait), 32'h3);
    check("rst_dwait", 32'(dwait), 32'h3);
    check("rst_ramren", 32'(ramREN), 32'h0);
    check("rst_ramwen", 32'(ramWEN), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    tick();
    RST = 1'b0;

    // single icache fetch, two BUSY cycles then ACCESS
    iREN = 2'b01; iaddr[0] = 32'h40;
    sample();
    check("t1_idle_ren", 32'(ramREN), 32'h0);
    tick();
    ramstate = BUSY;
    sample();
    check("t1_state", 32'(arb_state), 32'(IXFER));
    check("t1_ren", 32'(ramREN), 32'h1);
    check("t1_addr", ramaddr, 32'h40);
    check("t1_busy1_iwait", 32'(iwait), 32'h3);
    tick();
    sample();
    check("t1_busy2_iwait", 32'(iwait), 32'h3);
    tick();
    ramstate = ACCESS; ramload = 32'hDEADBEEF;
    sample();
    check("t1_done_iwait", 32'(iwait), 32'h2);
    check("t1_dwait", 32'(dwait), 32'h3);
    check("t1_iload0", iload[0], 32'hDEADBEEF);
    check("t1_iload1", iload[1], 32'hDEADBEEF);
    check("t1_dload0", dload[0], 32'hDEADBEEF);
    tick();
    iREN = '0; ramstate = FREE;
    sample();
    check("t1_back_idle", 32'(arb_state), 32'(IDLE));
    check("t1_idle_ren2", 32'(ramREN), 32'h0);
    tick();

    // core 1 dcache writeback burst while core 0 icache waits
    dWEN = 2'b10; daddr[1] = 32'h100; dstore[1] = 32'hA5A5A5A5;
    iREN = 2'b01; iaddr[0] = 32'h40;
    sample();
    check("t2_idle", 32'(arb_state), 32'(IDLE));
    tick();
    ramstate = ACCESS;
    sample();
    check("t2_w1_state", 32'(arb_state), 32'(DXFER1));
    check("t2_w1_wen", 32'(ramWEN), 32'h1);
    check("t2_w1_ren", 32'(ramREN), 32'h0);
    check("t2_w1_addr", ramaddr, 32'h100);
    check("t2_w1_data", ramstore, 32'hA5A5A5A5);
    check("t2_w1_dwait", 32'(dwait), 32'h1);
    check("t2_w1_iwait", 32'(iwait), 32'h3);
    tick();
    daddr[1] = 32'h104; dstore[1] = 32'h5A5A5A5A; ramstate = BUSY;
    sample();
    check("t2_w2_state", 32'(arb_state), 32'(DXFER2));
    check("t2_w2_busy_dwait", 32'(dwait), 32'h3);
    check("t2_w2_addr", ramaddr, 32'h104);
    tick();
    ramstate = ACCESS;
    sample();
    check("t2_w2_dwait", 32'(dwait), 32'h1);
    check("t2_w2_data", ramstore, 32'h5A5A5A5A);
    check("t2_w2_wen", 32'(ramWEN), 32'h1);
    tick();
    dWEN = '0;
    sample();
    check("t2_bubble", 32'(arb_state), 32'(IDLE));
    check("t2_bubble_ren", 32'(ramREN), 32'h0);
    check("t2_bubble_iwait", 32'(iwait), 32'h3);
    tick();
    sample();
    check("t2_i_state", 32'(arb_state), 32'(IXFER));
    check("t2_i_addr", ramaddr, 32'h40);
    check("t2_i_iwait", 32'(iwait), 32'h2);
    tick();
    iREN = '0; ramstate = FREE;
    tick();

    // dcache beats icache within one core
    iREN = 2'b01; iaddr[0] = 32'h44; dREN = 2'b01; daddr[0] = 32'h200; ramstate = ACCESS;
    tick();
    sample();
    check("t3_d_state", 32'(arb_state), 32'(DXFER1));
    check("t3_d_ren", 32'(ramREN), 32'h1);
    check("t3_d_addr", ramaddr, 32'h200);
    check("t3_d_dwait", 32'(dwait), 32'h2);
    check("t3_d_iwait", 32'(iwait), 32'h3);
    tick();
    sample();
    check("t3_d2_dwait", 32'(dwait), 32'h2);
    tick();
    dREN = '0;
    sample();
    check("t3_bubble", 32'(arb_state), 32'(IDLE));
    tick();
    sample();
    check("t3_i_state", 32'(arb_state), 32'(IXFER));
    check("t3_i_addr", ramaddr, 32'h44);
    check("t3_i_iwait", 32'(iwait), 32'h2);
    tick();
    iREN = '0;
    tick();

    // round robin with all four requesting, then icache only
    iREN = 2'b11; dREN = 2'b11;
    daddr[0] = 32'h300; daddr[1] = 32'h400; iaddr[0] = 32'h40; iaddr[1] = 32'h44;
    for (int i = 0; i < 4; i++) begin
      tick();
      sample();
      check($sformatf("t4_d%0d_state", i), 32'(arb_state), 32'(DXFER1));
      check($sformatf("t4_d%0d_addr", i), ramaddr, rr_d[i]);
      tick();
      tick();
    end
    dREN = '0;
    for (int i = 0; i < 4; i++) begin
      tick();
      sample();
      check($sformatf("t4_i%0d_state", i), 32'(arb_state), 32'(IXFER));
      check($sformatf("t4_i%0d_addr", i), ramaddr, rr_i[i]);
      tick();
    end
    iREN = '0;
    tick();

    // core 0 aborts after word 1; core 1 icache is then granted
    dREN = 2'b01; daddr[0] = 32'h500; iREN = 2'b10; iaddr[1] = 32'h600; ramstate = ACCESS;
    tick();
    sample();
    check("t5_w1_addr", ramaddr, 32'h500);
    check("t5_w1_dwait", 32'(dwait), 32'h2);
    tick();
    dREN = '0;
    sample();
    check("t5_abort_state", 32'(arb_state), 32'(DXFER2));
    check("t5_abort_dwait", 32'(dwait), 32'h3);
    check("t5_abort_ren", 32'(ramREN), 32'h0);
    tick();
    sample();
    check("t5_idle", 32'(arb_state), 32'(IDLE));
    tick();
    sample();
    check("t5_i1_state", 32'(arb_state), 32'(IXFER));
    check("t5_i1_addr", ramaddr, 32'h600);
    check("t5_i1_iwait", 32'(iwait), 32'h1);
    tick();
    iREN = '0; ramstate = FREE;
    tick();

    // ERROR completes the word and sets sticky err
    iREN = 2'b01; iaddr[0] = 32'h700;
    tick();
    ramstate = ERROR;
    sample();
    check("t6_state", 32'(arb_state), 32'(IXFER));
    check("t6_iwait", 32'(iwait), 32'h2);
    check("t6_err_pre", 32'(err), 32'h0);
    tick();
    iREN = '0; ramstate = FREE;
    sample();
    check("t6_err_set", 32'(err), 32'h1);
    check("t6_idle", 32'(arb_state), 32'(IDLE));
    tick();
    sample();
    check("t6_err_sticky", 32'(err), 32'h1);
    RST = 1'b1;
    #1;
    check("t6_err_cleared", 32'(err), 32'h0);
    tick();
    RST = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
